flit_inject_tx: RTL
===================

// Module: flit_inject_tx
// PURPOSE
//  Injection-side transmitter between a node's packet source and its router's local injection port.
//  Accepts one whole packet (NUM_FLIT payload words) per ready/valid handshake.
//  Serialises the packet into NUM_FLIT flits. Presents one flit at a time on a registered output and
//  advances only on cycles the router grants an injection slot.
//  The local ejection logic on the far side of the router is the receiving end of this flit format.
// PARAMETERS
//  DATA_W    32  payload bits per flit
//  NUM_FLIT  4   flits per packet (>=2)
//  ADDR_W    4   node address width (dst/src fields)
//  ID_W      4   packet id width; counter wraps modulo 2**ID_W
//  FIDX_W    2   flit index width, = clog2(NUM_FLIT)
//  FLIT_W    DATA_W+2*ADDR_W+ID_W+FIDX_W+1  (derived, localparam)
// PORTS
//  clk          in   1                  clock, all state on posedge
//  reset        in   1                  asynchronous active-low reset
//  my_addr      in   ADDR_W             this node's address, static
//  pkt_valid    in   1                  packet offered
//  pkt_ready    out  1                  transmitter can accept a packet
//  pkt_dst      in   ADDR_W             destination node
//  pkt_payload  in   NUM_FLIT*DATA_W    word i = bits [i*DATA_W +: DATA_W], sent as flit i
//  inj_grant    in   1                  router has a free output slot; current flit consumed this cycle
//  flit_valid   out  1                  flit_out holds a flit to inject
//  flit_out     out  FLIT_W             {tail, fidx, pkt_id, src, dst, data}, tail is MSB
//  busy         out  1                  packet in flight (state != IDLE)
// BEHAVIOUR
//  Reset (reset==0, async):
//   - state=IDLE, flit_valid=0, flit_out=0, pkt_id counter=0, flit index=0, packet buffer=0.
//   - pkt_ready=1, busy=0 from reset release.
//  FSM IDLE/SEND; pkt_ready = (state==IDLE), busy = (state==SEND), both decoded from registered state.
//  IDLE:
//   - pkt_valid&pkt_ready at edge k: capture dst, payload, pkt_id.
//   - Load flit 0 into flit_out, set flit_valid=1, enter SEND.
//   - Flit 0 is visible in cycle k+1, so packet-to-first-flit latency is 1 cycle.
//  SEND, inj_grant=0: flit_out and flit_valid hold unchanged; a stall may be any length.
//  SEND, inj_grant=1, fidx<NUM_FLIT-1: load flit fidx+1 at the edge.
//  SEND, inj_grant=1, fidx==NUM_FLIT-1 (tail):
//   - flit_valid<=0, pkt_id<=pkt_id+1 (wraps 2**ID_W-1 -> 0), enter IDLE.
//   - Next packet is accepted no earlier than the following edge, giving one bubble cycle between packets.
//  Flit fields:
//   - dst=captured pkt_dst; src=my_addr sampled at capture.
//   - fidx=flit number 0..NUM_FLIT-1; tail=1 only when fidx==NUM_FLIT-1.
//   - pkt_id is the same for all flits of a packet.
//  inj_grant while flit_valid==0 is ignored. pkt_valid while pkt_ready==0 is ignored and the source must hold it.
//  Payload and dst are buffered at capture; pkt_payload changes after acceptance do not affect flits.
//  Reset asserted mid-packet: remaining flits are dropped, flit_valid falls asynchronously, pkt_id returns to 0.
//  No combinational path from any input to any output.
// TESTING
//  - Reset release, pkt_valid=0: pkt_ready=1, flit_valid=0, busy=0, flit_out=0.
//  - my_addr=3, packet dst=5, payload words A0..A3, inj_grant=1 held:
//    - flits on 4 consecutive cycles starting 1 cycle after acceptance, fidx 0,1,2,3, data A0..A3, pkt_id=0, tail only on fidx 3.
//    - pkt_ready returns 1 the cycle after the tail flit.
//  - Same packet, inj_grant low for 3 cycles while fidx=1:
//    - flit fidx=1 held stable for all 3 cycles.
//    - Flits 2,3 follow once the grant returns; 4 flits total, no duplicates.
//  - 17 back-to-back packets, grant always high:
//    - pkt_id runs 0..15 then 0.
//    - Exactly 1 idle cycle between each tail flit and the next head flit.
//  - Reset pulsed while flit fidx=2 is pending:
//    - flit_valid=0 immediately, no further flits.
//    - After release pkt_ready=1, and the next packet starts at fidx 0 with pkt_id=0.
//  - pkt_valid held with changing payload during SEND: no second capture; flits carry the payload captured at acceptance.

Source files
------------

// File: rtl/flit_inject_tx_if.sv
// Packet-source and router-injection handshake bundle for flit_inject_tx.
// The slave modport is the transmitter. The master modport is the node/router side that drives packets and grants.
interface flit_inject_tx_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_FLIT = 4,
    parameter int ADDR_W   = 4,
    parameter int ID_W     = 4,
    parameter int FIDX_W   = 2
) ();
    localparam int FLIT_W = DATA_W + 2*ADDR_W + ID_W + FIDX_W + 1;

    logic                         pkt_valid;
    logic                         pkt_ready;
    logic [ADDR_W-1:0]            pkt_dst;
    logic [NUM_FLIT*DATA_W-1:0]   pkt_payload;
    logic                         inj_grant;
    logic                         flit_valid;
    logic [FLIT_W-1:0]            flit_out;
    logic                         busy;

    modport master (
        output pkt_valid, pkt_dst, pkt_payload, inj_grant,
        input  pkt_ready, flit_valid, flit_out, busy
    );

    modport slave (
        input  pkt_valid, pkt_dst, pkt_payload, inj_grant,
        output pkt_ready, flit_valid, flit_out, busy
    );
endinterface

// File: rtl/flit_inject_tx.sv
// Serialises one buffered packet into NUM_FLIT flits for the router's local injection port.
// Latency: the head flit is registered 1 cycle after acceptance. There is one bubble cycle after the tail before the next packet is accepted.
// Backpressure: a low inj_grant holds the current flit indefinitely. pkt_ready is low for the whole packet.
module flit_inject_tx #(
    parameter int DATA_W   = 32,
    parameter int NUM_FLIT = 4,
    parameter int ADDR_W   = 4,
    parameter int ID_W     = 4,
    parameter int FIDX_W   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  my_addr,
    flit_inject_tx_if.slave    bus
);
    localparam int FLIT_W = DATA_W + 2*ADDR_W + ID_W + FIDX_W + 1;
    localparam logic [FIDX_W-1:0] LAST_IDX = FIDX_W'(NUM_FLIT - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                     state, state_nx;
    logic                       fv_q, fv_nx;
    logic [FLIT_W-1:0]          fo_q, fo_nx;
    logic [ID_W-1:0]            id_q, id_nx;
    logic [FIDX_W-1:0]          fidx_q, fidx_nx;
    logic [NUM_FLIT*DATA_W-1:0] pay_q, pay_nx;
    logic [ADDR_W-1:0]          dst_q, dst_nx;
    logic [ADDR_W-1:0]          src_q, src_nx;
    logic [FIDX_W-1:0]          nidx;

    function automatic logic [FLIT_W-1:0] make_flit(
        input logic [FIDX_W-1:0] idx,
        input logic [ID_W-1:0]   id,
        input logic [ADDR_W-1:0] src,
        input logic [ADDR_W-1:0] dst,
        input logic [DATA_W-1:0] d
    );
        return {(idx == LAST_IDX), idx, id, src, dst, d};
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            fv_q   <= 1'b0;
            fo_q   <= '0;
            id_q   <= '0;
            fidx_q <= '0;
            pay_q  <= '0;
            dst_q  <= '0;
            src_q  <= '0;
        end else begin
            state  <= state_nx;
            fv_q   <= fv_nx;
            fo_q   <= fo_nx;
            id_q   <= id_nx;
            fidx_q <= fidx_nx;
            pay_q  <= pay_nx;
            dst_q  <= dst_nx;
            src_q  <= src_nx;
        end
    end

    always_comb begin
        state_nx = state;
        fv_nx    = fv_q;
        fo_nx    = fo_q;
        id_nx    = id_q;
        fidx_nx  = fidx_q;
        pay_nx   = pay_q;
        dst_nx   = dst_q;
        src_nx   = src_q;
        nidx     = fidx_q + 1'b1;
        case (state)
            IDLE: begin
                if (bus.pkt_valid) begin
                    pay_nx   = bus.pkt_payload;
                    dst_nx   = bus.pkt_dst;
                    src_nx   = my_addr;
                    fidx_nx  = '0;
                    fo_nx    = make_flit('0, id_q, my_addr, bus.pkt_dst, bus.pkt_payload[0 +: DATA_W]);
                    fv_nx    = 1'b1;
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (bus.inj_grant) begin
                    if (fidx_q == LAST_IDX) begin
                        fv_nx    = 1'b0;
                        id_nx    = id_q + 1'b1;
                        fidx_nx  = '0;
                        state_nx = IDLE;
                    end else begin
                        fidx_nx = nidx;
                        fo_nx   = make_flit(nidx, id_q, src_q, dst_q, pay_q[int'(nidx)*DATA_W +: DATA_W]);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.pkt_ready  = (state == IDLE);
    assign bus.busy       = (state == SEND);
    assign bus.flit_valid = fv_q;
    assign bus.flit_out   = fo_q;
endmodule
